// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the Wishbone SRAM responder.
//   resp_state_t : serving FSM state encoding (IDLE / WAIT / RESP)
//   wb_req_t     : one accepted request as held in the in-order queue
//   apply_sel    : byte-lane merge of write data into an existing word
package ecap5_dproc_pkg;

   typedef logic [1:0] resp_state_t;

   localparam resp_state_t StIdle = 2'd0;
   localparam resp_state_t StWait = 2'd1;
   localparam resp_state_t StResp = 2'd2;

   // adr is the word index (byte address bits [31:2]).
   typedef struct packed {
      logic [29:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
   } wb_req_t;

   function automatic logic [31:0] apply_sel(logic [31:0] old_word, logic [31:0] wr_word,
                                             logic [3:0] sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? wr_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_sram_responder_if.sv
// Wishbone B4 pipelined bus bundle between a master and the SRAM responder.
//   adr, dat_w, we, sel, stb, cyc : master -> slave
//   dat_r, ack, err, stall        : slave -> master
interface wb_sram_responder_if;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        we;
   logic [3:0]  sel;
   logic        stb;
   logic        cyc;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (output adr, dat_w, we, sel, stb, cyc,
                   input  dat_r, ack, err, stall);

   modport slave  (input  adr, dat_w, we, sel, stb, cyc,
                   output dat_r, ack, err, stall);
endinterface

// File: rtl/wb_req_queue.sv
// In-order request queue holding up to QUEUE_DEPTH accepted Wishbone requests.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   flush_i      : drop every entry (takes priority over push/pop)
//   push_i       : enqueue push_data_i
//   pop_i        : dequeue the head entry
//   count_o      : registered number of valid entries
//   head_o       : oldest entry (valid while count_o != 0)
module wb_req_queue
   import ecap5_dproc_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       flush_i,
   input  logic       push_i,
   input  wb_req_t    push_data_i,
   input  logic       pop_i,
   output logic [2:0] count_o,
   output wb_req_t    head_o
);

   // Storage sized for the largest legal depth so 2-bit pointers index it cleanly.
   localparam int unsigned MaxEntries = 4;

   wb_req_t    entry_q [MaxEntries];
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [2:0] count_q, count_d;
   logic       do_push, do_pop;

   function automatic logic [1:0] next_ptr(logic [1:0] p);
      return (32'(p) == QUEUE_DEPTH - 1) ? 2'd0 : p + 2'd1;
   endfunction

   assign do_push = push_i & (count_q != 3'(QUEUE_DEPTH));
   assign do_pop  = pop_i & (count_q != 3'd0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 2'd0;
         wr_ptr_d = 2'd0;
         count_d  = 3'd0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         count_d = count_q + 3'(do_push) - 3'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_ptr_q <= 2'd0;
         wr_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset; only entries counted by count_q are ever observed.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) entry_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone B4 pipelined slave fronting a DEPTH x 32-bit register-array SRAM.
// Requests are queued in order, each waits LATENCY cycles, then completes for
// exactly one cycle with ack (in range) or err (out of range).
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   wb_io : Wishbone slave modport (adr/dat_w/we/sel/stb/cyc in, dat_r/ack/err/stall out)
module wb_sram_responder
   import ecap5_dproc_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input logic                 clk_i,
   input logic                 rst_i,
   wb_sram_responder_if.slave  wb_io
);

   localparam int unsigned AdrW    = $clog2(DEPTH);
   localparam logic [2:0]  LatLoad = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

   resp_state_t state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  count, count_after;
   wb_req_t     push_req, head;
   logic        stall, push, completing, in_range, mem_wr;
   logic [31:0] mem_q [DEPTH];
   logic [AdrW-1:0] mem_idx;
   logic        unused_adr_lsb;

   assign unused_adr_lsb = ^wb_io.adr[1:0];

   assign push_req = '{adr: wb_io.adr[31:2], we: wb_io.we, sel: wb_io.sel, dat: wb_io.dat_w};

   // Stall follows the registered count, so a same-cycle pop frees a slot one cycle later.
   assign stall      = (count == 3'(QUEUE_DEPTH));
   assign push       = wb_io.cyc & wb_io.stb & ~stall;
   assign completing = (state_q == StResp) & wb_io.cyc;
   assign in_range   = (head.adr < 30'(DEPTH));
   assign mem_idx    = head.adr[AdrW-1:0];
   assign mem_wr     = completing & head.we & in_range;

   wb_req_queue #(
      .QUEUE_DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (~wb_io.cyc),
      .push_i      (push),
      .push_data_i (push_req),
      .pop_i       (completing),
      .count_o     (count),
      .head_o      (head)
   );

   assign count_after = count + 3'(push) - 3'(completing);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!wb_io.cyc) begin
         state_d = StIdle;
         cnt_d   = 3'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (push) begin
                  state_d = (LATENCY == 0) ? StResp : StWait;
                  cnt_d   = LatLoad;
               end
            end
            StWait: begin
               if (cnt_q == 3'd0) state_d = StResp;
               else               cnt_d   = cnt_q - 3'd1;
            end
            StResp: begin
               if (count_after != 3'd0) begin
                  state_d = (LATENCY == 0) ? StResp : StWait;
                  cnt_d   = LatLoad;
               end else begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory is intentionally not reset; contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (mem_wr) mem_q[mem_idx] <= apply_sel(mem_q[mem_idx], head.dat, head.sel);
   end

   always_comb begin
      wb_io.ack   = completing & in_range;
      wb_io.err   = completing & ~in_range;
      wb_io.stall = stall;
      wb_io.dat_r = (completing && in_range && !head.we) ? mem_q[mem_idx] : 32'd0;
   end

endmodule

// File: tb/tb_wb_sram_responder.sv
module tb_wb_sram_responder;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        exp_ack;
      logic        exp_err;
      logic [31:0] exp_dat;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Index 0: LATENCY=0, 1: LATENCY=1, 2: LATENCY=3 (all DEPTH=256, QUEUE_DEPTH=2).
   logic        cyc_v [3];
   logic        stb_v [3];
   logic        we_v  [3];
   logic [31:0] adr_v [3];
   logic [31:0] dat_v [3];
   logic [3:0]  sel_v [3];
   logic        ack_v [3];
   logic        err_v [3];
   logic        stall_v [3];
   logic [31:0] rdat_v [3];

   int n_tests = 0;
   int n_fail  = 0;

   wb_sram_responder_if bus0 ();
   wb_sram_responder_if bus1 ();
   wb_sram_responder_if bus3 ();

   assign bus0.cyc = cyc_v[0];  assign bus0.stb = stb_v[0];  assign bus0.we = we_v[0];
   assign bus0.adr = adr_v[0];  assign bus0.dat_w = dat_v[0]; assign bus0.sel = sel_v[0];
   assign ack_v[0] = bus0.ack;  assign err_v[0] = bus0.err;
   assign stall_v[0] = bus0.stall; assign rdat_v[0] = bus0.dat_r;

   assign bus1.cyc = cyc_v[1];  assign bus1.stb = stb_v[1];  assign bus1.we = we_v[1];
   assign bus1.adr = adr_v[1];  assign bus1.dat_w = dat_v[1]; assign bus1.sel = sel_v[1];
   assign ack_v[1] = bus1.ack;  assign err_v[1] = bus1.err;
   assign stall_v[1] = bus1.stall; assign rdat_v[1] = bus1.dat_r;

   assign bus3.cyc = cyc_v[2];  assign bus3.stb = stb_v[2];  assign bus3.we = we_v[2];
   assign bus3.adr = adr_v[2];  assign bus3.dat_w = dat_v[2]; assign bus3.sel = sel_v[2];
   assign ack_v[2] = bus3.ack;  assign err_v[2] = bus3.err;
   assign stall_v[2] = bus3.stall; assign rdat_v[2] = bus3.dat_r;

   wb_sram_responder #(.DEPTH(256), .LATENCY(0), .QUEUE_DEPTH(2)) u_l0 (
      .clk_i (clk), .rst_i (rst_n), .wb_io (bus0.slave));
   wb_sram_responder #(.DEPTH(256), .LATENCY(1), .QUEUE_DEPTH(2)) u_l1 (
      .clk_i (clk), .rst_i (rst_n), .wb_io (bus1.slave));
   wb_sram_responder #(.DEPTH(256), .LATENCY(3), .QUEUE_DEPTH(2)) u_l3 (
      .clk_i (clk), .rst_i (rst_n), .wb_io (bus3.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input int idx, input logic cyc, input logic stb, input vec_t v);
      cyc_v[idx] = cyc;
      stb_v[idx] = stb;
      we_v[idx]  = v.we;
      adr_v[idx] = v.adr;
      sel_v[idx] = v.sel;
      dat_v[idx] = v.dat;
   endtask

   task automatic check_idle_outputs(input string name, input int idx);
      check({name, " ack"},   32'(ack_v[idx]),   32'd0);
      check({name, " err"},   32'(err_v[idx]),   32'd0);
      check({name, " stall"}, 32'(stall_v[idx]), 32'd0);
      check({name, " dat"},   rdat_v[idx],       32'd0);
   endtask

   // Single transaction: completion must appear in the cycle after edge k+lat.
   task automatic xfer(input int idx, input int lat, input vec_t v, input string name);
      int seen;
      seen = -1;
      @(posedge clk); #1;
      drive(idx, 1'b1, 1'b1, v);
      @(negedge clk);
      check({name, " stall"}, 32'(stall_v[idx]), 32'd0);
      @(posedge clk); #1;
      stb_v[idx] = 1'b0;
      for (int c = 1; c <= lat + 4 && seen < 0; c++) begin
         @(negedge clk);
         if (ack_v[idx] || err_v[idx]) begin
            seen = c;
            check({name, " ack"}, 32'(ack_v[idx]), 32'(v.exp_ack));
            check({name, " err"}, 32'(err_v[idx]), 32'(v.exp_err));
            check({name, " dat"}, rdat_v[idx], v.exp_dat);
         end
      end
      check({name, " latency"}, 32'(seen), 32'(lat + 1));
      @(negedge clk);
      check({name, " one-cycle"}, {30'd0, ack_v[idx], err_v[idx]}, 32'd0);
      @(posedge clk); #1;
      cyc_v[idx] = 1'b0;
   endtask

   vec_t l1_tab [13];
   vec_t l0_burst [9];
   vec_t rq;

   logic        l3_stall [13];
   logic        l3_ack   [13];
   logic [31:0] l3_dat   [13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Single transactions on LATENCY=1.
      l1_tab[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      l1_tab[1]  = '{1'b0, 32'h10,  4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      l1_tab[2]  = '{1'b1, 32'h20,  4'hF, 32'h11223344, 1'b1, 1'b0, 32'h0};
      l1_tab[3]  = '{1'b1, 32'h20,  4'h5, 32'hAABBCCDD, 1'b1, 1'b0, 32'h0};
      l1_tab[4]  = '{1'b0, 32'h20,  4'hF, 32'h0,        1'b1, 1'b0, 32'h11BB33DD};
      l1_tab[5]  = '{1'b1, 32'h00,  4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0};
      l1_tab[6]  = '{1'b0, 32'h400, 4'hF, 32'h0,        1'b0, 1'b1, 32'h0};
      l1_tab[7]  = '{1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0};
      l1_tab[8]  = '{1'b0, 32'h00,  4'hF, 32'h0,        1'b1, 1'b0, 32'h12345678};
      l1_tab[9]  = '{1'b1, 32'h10,  4'h0, 32'h00000000, 1'b1, 1'b0, 32'h0};
      l1_tab[10] = '{1'b0, 32'h13,  4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      l1_tab[11] = '{1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
      l1_tab[12] = '{1'b0, 32'h3FC, 4'hF, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};

      // Pipelined burst on LATENCY=0, including read-behind-write to 0x50.
      l0_burst[0] = '{1'b1, 32'h40, 4'hF, 32'hA0000000, 1'b1, 1'b0, 32'h0};
      l0_burst[1] = '{1'b1, 32'h44, 4'hF, 32'hA1111111, 1'b1, 1'b0, 32'h0};
      l0_burst[2] = '{1'b1, 32'h48, 4'hF, 32'hA2222222, 1'b1, 1'b0, 32'h0};
      l0_burst[3] = '{1'b1, 32'h4C, 4'hF, 32'hA3333333, 1'b1, 1'b0, 32'h0};
      l0_burst[4] = '{1'b1, 32'h50, 4'hF, 32'h77665544, 1'b1, 1'b0, 32'h0};
      l0_burst[5] = '{1'b0, 32'h50, 4'hF, 32'h0,        1'b1, 1'b0, 32'h77665544};
      l0_burst[6] = '{1'b0, 32'h40, 4'hF, 32'h0,        1'b1, 1'b0, 32'hA0000000};
      l0_burst[7] = '{1'b0, 32'h44, 4'hF, 32'h0,        1'b1, 1'b0, 32'hA1111111};
      l0_burst[8] = '{1'b0, 32'h4C, 4'hF, 32'h0,        1'b1, 1'b0, 32'hA3333333};

      // LATENCY=3 three-request schedule; entry c is the cycle after edge c.
      for (int c = 0; c < 13; c++) begin
         l3_stall[c] = ((c >= 1 && c <= 3) || (c >= 5 && c <= 7));
         l3_ack[c]   = (c == 3 || c == 7 || c == 11);
         l3_dat[c]   = (c == 11) ? 32'h11111111 : 32'h0;
      end

      rq = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, rq);

      // Reset state, during and after reset.
      rst_n = 1'b0;
      #12;
      check_idle_outputs("reset l0", 0);
      check_idle_outputs("reset l1", 1);
      check_idle_outputs("reset l3", 2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("post-reset l1", 1);

      for (int i = 0; i < 13; i++) xfer(1, 1, l1_tab[i], $sformatf("l1 vec%0d", i));

      // LATENCY=0 back-to-back burst: no stall, one ack per cycle in order.
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         if (i < 9) drive(0, 1'b1, 1'b1, l0_burst[i]);
         else stb_v[0] = 1'b0;
         @(negedge clk);
         if (i < 9) check($sformatf("l0 burst%0d stall", i), 32'(stall_v[0]), 32'd0);
         if (i > 0) begin
            check($sformatf("l0 burst%0d ack", i - 1), 32'(ack_v[0]), 32'd1);
            check($sformatf("l0 burst%0d dat", i - 1), rdat_v[0], l0_burst[i - 1].exp_dat);
         end else begin
            check("l0 burst pre ack", 32'(ack_v[0]), 32'd0);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("l0 burst tail ack", 32'(ack_v[0]), 32'd0);
      cyc_v[0] = 1'b0;

      // LATENCY=3 queue-full stall and in-order completion.
      @(posedge clk); #1;
      rq = '{1'b1, 32'h60, 4'hF, 32'h11111111, 1'b0, 1'b0, 32'h0};
      drive(2, 1'b1, 1'b1, rq);
      @(posedge clk); #1;
      for (int c = 0; c < 13; c++) begin
         if (c == 0) begin
            rq = '{1'b1, 32'h64, 4'hF, 32'h22222222, 1'b0, 1'b0, 32'h0};
            drive(2, 1'b1, 1'b1, rq);
         end
         if (c == 1) begin
            rq = '{1'b0, 32'h60, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
            drive(2, 1'b1, 1'b1, rq);
         end
         if (c == 5) stb_v[2] = 1'b0;
         @(negedge clk);
         check($sformatf("l3 c%0d stall", c), 32'(stall_v[2]), 32'(l3_stall[c]));
         check($sformatf("l3 c%0d ack/err", c), {30'd0, ack_v[2], err_v[2]},
               {30'd0, l3_ack[c], 1'b0});
         check($sformatf("l3 c%0d dat", c), rdat_v[2], l3_dat[c]);
         @(posedge clk); #1;
      end
      cyc_v[2] = 1'b0;

      // Dropping cyc discards a pending write.
      rq = '{1'b1, 32'h30, 4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};
      xfer(2, 3, rq, "l3 preload");
      @(posedge clk); #1;
      rq = '{1'b1, 32'h30, 4'hF, 32'h55555555, 1'b0, 1'b0, 32'h0};
      drive(2, 1'b1, 1'b1, rq);
      @(posedge clk); #1;
      stb_v[2] = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("cyc drop c%0d", c), {30'd0, ack_v[2], err_v[2]}, 32'd0);
         @(posedge clk); #1;
         if (c == 1) cyc_v[2] = 1'b0;
      end

      // stb without cyc is ignored.
      rq = '{1'b1, 32'h30, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
      drive(2, 1'b0, 1'b1, rq);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("stb no cyc c%0d", c),
               {29'd0, ack_v[2], err_v[2], stall_v[2]}, 32'd0);
         @(posedge clk); #1;
      end
      stb_v[2] = 1'b0;
      rq = '{1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0BADF00D};
      xfer(2, 3, rq, "l3 readback 0x30");

      // Reset in the middle of a completion with the queue full.
      @(posedge clk); #1;
      rq = '{1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
      drive(2, 1'b1, 1'b1, rq);
      @(posedge clk); #1;
      @(posedge clk); #1;
      stb_v[2] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre-reset ack",   32'(ack_v[2]),   32'd1);
      check("pre-reset stall", 32'(stall_v[2]), 32'd1);
      check("pre-reset dat",   rdat_v[2],       32'h0BADF00D);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid reset", 2);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("after reset c%0d", c), {30'd0, ack_v[2], err_v[2]}, 32'd0);
      end
      cyc_v[2] = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_sram_responder.md
WB_SRAM_RESPONDER -- requirements
Module: wb_sram_responder

Interface
REQ-001 Parameter DEPTH, default 256, memory size in 32-bit words (power of two, 4..4096).
REQ-002 Parameter LATENCY, default 1, wait cycles between acceptance and response (0..7).
REQ-003 Parameter QUEUE_DEPTH, default 2, maximum outstanding accepted requests (1..4).
REQ-004 clk_i  in  1  single clock; all state changes on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 wb_adr_i  in  32  byte address; bits [1:0] ignored.
REQ-007 wb_dat_i  in  32  write data.
REQ-008 wb_dat_o  out  32  read data, valid only while wb_ack_o high.
REQ-009 wb_we_i  in  1  1 = write, 0 = read.
REQ-010 wb_sel_i  in  4  byte-lane enables; bit n covers bits [8n+7:8n].
REQ-011 wb_stb_i  in  1  request strobe.
REQ-012 wb_cyc_i  in  1  bus cycle active.
REQ-013 wb_ack_o  out  1  successful completion, one cycle per request.
REQ-014 wb_err_o  out  1  failed completion (address out of range), one cycle per request.
REQ-015 wb_stall_o  out  1  request not accepted this cycle.

Function
REQ-016 Protocol is Wishbone B4 pipelined, slave side; acceptance = wb_cyc_i & wb_stb_i & ~wb_stall_o at a rising edge.
REQ-017 Each accepted request (address, we, sel, write data) is pushed into an in-order queue of QUEUE_DEPTH entries.
REQ-018 wb_stall_o = 1 when the registered queue count equals QUEUE_DEPTH; a pop in the same cycle does not clear stall until the next cycle.
REQ-019 Serving FSM states: IDLE (queue empty), WAIT (counting down LATENCY for the head entry), RESP (completion asserted for the head entry).
REQ-020 IDLE -> WAIT on push when LATENCY > 0; IDLE -> RESP on push when LATENCY = 0.
REQ-021 WAIT: 3-bit counter loaded with LATENCY-1 on entry, decremented each cycle; -> RESP when counter = 0.
REQ-022 RESP: lasts exactly one cycle and pops the head; then -> RESP (LATENCY = 0) or WAIT (LATENCY > 0) if the queue is still non-empty after the push/pop, otherwise -> IDLE.
REQ-023 A request accepted at edge k whose predecessors are complete has its completion asserted in the cycle after edge k+LATENCY.
REQ-024 With LATENCY = 0, back-to-back requests complete one per cycle.
REQ-025 Completions return in acceptance order; exactly one of wb_ack_o or wb_err_o is asserted per request.
REQ-026 In-range means word index adr[31:2] < DEPTH; out-of-range asserts wb_err_o, performs no write, and drives wb_dat_o = 0.
REQ-027 Writes update only sel-enabled bytes at the rising edge that ends the RESP cycle; sel = 0 acks with no change.
REQ-028 Reads drive the memory word into wb_dat_o during RESP; wb_dat_o = 0 in every other cycle.
REQ-029 A read queued behind a write to the same word returns the written data.
REQ-030 wb_cyc_i low in any cycle: queue flushed, counter cleared, FSM -> IDLE at the next edge, and no completion is asserted in that cycle; pending writes are discarded.
REQ-031 wb_stb_i while wb_cyc_i is low is ignored.

Reset
REQ-032 During reset and after release: wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, wb_stall_o = 0, queue empty, FSM = IDLE, counter = 0.
REQ-033 Reset asserted mid-operation drops all queued requests without completion; memory contents are retained (not reset) and undefined after power-up.

Structure
REQ-034 The FSM state enum and the queued-request struct (adr, we, sel, dat) belong in ecap5_dproc_pkg.
REQ-035 The request queue is a sub-module named wb_req_queue (push, pop, count, head outputs; flush input).
REQ-036 Memory is a synchronous-write register array of DEPTH x 32 bits inferable as block RAM.

Verification
REQ-037 LATENCY=1: write 0xDEADBEEF to 0x10 (sel=0xF), then read 0x10 -> ack 2 cycles after each acceptance; read dat_o=0xDEADBEEF.
REQ-038 Byte lanes: write 0x11223344 to 0x20 with sel=0xF, then 0xAABBCCDD with sel=0x5 -> read returns 0x11BB33DD.
REQ-039 LATENCY=0, QUEUE_DEPTH=2: four reads issued with stb held high -> stall never asserted; four consecutive one-cycle acks in order.
REQ-040 LATENCY=3, QUEUE_DEPTH=2: three back-to-back requests -> stall high after second acceptance; third accepted only after the first ack; acks in order.
REQ-041 DEPTH=256: read from 0x400 -> wb_err_o for one cycle, ack stays 0, dat_o=0; write to 0x400 alters no word.
REQ-042 LATENCY=3: accept write to 0x30, drop cyc after 1 cycle -> no ack/err; later read of 0x30 returns prior contents; rst_i low mid-request -> all outputs 0 immediately.
